uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares the single UART transmitter among NUM_REQ byte producers.
- Each requester has a valid/ready byte channel and its own parity setting.
- The block owns the UART's tx_data_word, tx_start and cfg_parity_setting inputs, and watches tx_ready to sequence one frame at a time.
- It sits between the producers and the uart instance, in the uart clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, grant index width; must equal clog2(NUM_REQ).
- BUSY_TIMEOUT, 64, clk cycles allowed after tx_start for tx_ready to fall.
- TO_W, 8, timeout counter width; must satisfy BUSY_TIMEOUT <= 2^TO_W.

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  byte of requester i is at bits [8i+7:8i].
- req_parity  in  2*NUM_REQ  parity setting of requester i is at [2i+1:2i] (00 none, 01 odd, 10 even).
- req_ready  out  NUM_REQ  one-hot accept strobe.
- uart_tx_ready  in  1  from uart tx_ready; 1 means the transmitter is idle.
- uart_tx_start  out  1  to uart tx_start.
- uart_tx_data  out  8  to uart tx_data_word.
- uart_parity  out  2  to uart cfg_parity_setting.
- grant_id  out  ID_W  index of the requester owning the link.
- busy  out  1  high in any state other than ARB.
- frame_done  out  1  one-cycle pulse when a frame completes.
- err_timeout  out  1  sticky flag: the UART did not start a frame; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0): state=ARB, rr_ptr=0, timer=0, uart_tx_start=0, uart_tx_data=0, uart_parity=00, grant_id=0, busy=0, frame_done=0, err_timeout=0, req_ready=0. A reset mid-frame abandons the frame; uart_tx_start is low while rst_n=0.
- Arbitration (combinational, used only in ARB):
  - The winner is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[winner]=1 in that same cycle; all other bits are 0. req_ready is 0 in every other state.
- A transfer happens on valid&ready. Registered on that edge:
  - uart_tx_data <= req_data[winner]
  - uart_parity <= req_parity[winner]
  - grant_id <= winner
  - rr_ptr <= winner+1, wrapping at NUM_REQ
  - state <= START
- With no valid in ARB, the block holds; outputs keep their last data/parity/grant values.
- START: uart_tx_start=1 for exactly this one cycle (registered output). timer <= 0. Next state WAIT_BUSY.
- WAIT_BUSY:
  - If uart_tx_ready=0, go to WAIT_DONE.
  - Otherwise timer++. When timer reaches BUSY_TIMEOUT-1 with uart_tx_ready still 1: set err_timeout, go to ARB. The byte is dropped, with no retry and no frame_done.
- WAIT_DONE: when uart_tx_ready=1, go to ARB and pulse frame_done on that transition cycle.
- uart_tx_data, uart_parity and grant_id stay stable from START through the WAIT_DONE exit, because the UART samples parity during its start state.
- Latency: valid seen in ARB cycle N gives req_ready in cycle N and uart_tx_start high in cycle N+1. From frame_done, the next grant can occur in the following cycle.
- Simultaneous valids are served in round-robin order. A requester that deasserts valid before it is granted is skipped with no penalty.
- A requester that keeps valid high is granted again only after every other valid requester has been served once.
- Changes to req_data or req_parity after acceptance have no effect on the frame in progress.
- timer saturates and never wraps; there is no overflow path.

Test Plan:
- Reset, then req_valid=0001 with data 0x55, parity 10 → req_ready=0001 in the same cycle. Next cycle: uart_tx_start=1, uart_tx_data=0x55, uart_parity=10, grant_id=0. Model tx_ready low for 100 cycles, then high → frame_done is a single pulse.
- req_valid=1111 held high, data i→0xA0+i → grant order 0,1,2,3,0; UART-model bytes are A0, A1, A2, A3, A0.
- rr_ptr=2 and only req_valid[1]=1 → wraps to grant 1. Next grant with all four valid → 2.
- Model tx_ready stuck at 1 → after 64 cycles in WAIT_BUSY, err_timeout=1, state returns to ARB, no frame_done. The next request is still served and err_timeout stays 1.
- Assert rst_n=0 during WAIT_DONE → all outputs take reset values immediately, with no clock edge needed. After release, the first grant goes to requester 0 when all are valid.
- Change req_data[0] and req_parity[0] during WAIT_DONE → uart_tx_data and uart_parity are unchanged until frame_done.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the producer byte channels and the UART transmitter link shared by
// uart_tx_arbiter.
//   req_valid   [NUM_REQ]     per-requester byte valid
//   req_data    [8*NUM_REQ]   byte of requester i at [8i+7:8i]
//   req_parity  [2*NUM_REQ]   parity of requester i at [2i+1:2i] (00 none, 01 odd, 10 even)
//   req_ready   [NUM_REQ]     one-hot accept strobe from the arbiter
//   uart_tx_ready             UART transmitter idle
//   uart_tx_start             start pulse to the UART
//   uart_tx_data  [8]         byte to the UART
//   uart_parity   [2]         parity setting to the UART
// Modports: slave = arbiter side, master = producers + UART side.
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [2*NUM_REQ-1:0] req_parity;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 uart_tx_ready;
   logic                 uart_tx_start;
   logic [7:0]           uart_tx_data;
   logic [1:0]           uart_parity;

   modport slave (
      input  req_valid, req_data, req_parity, uart_tx_ready,
      output req_ready, uart_tx_start, uart_tx_data, uart_parity
   );

   modport master (
      output req_valid, req_data, req_parity, uart_tx_ready,
      input  req_ready, uart_tx_start, uart_tx_data, uart_parity
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte
// producers. One frame is in flight at a time: a byte is accepted in ARB,
// tx_start is pulsed in START, the block waits for the UART to go busy
// (WAIT_BUSY, bounded by BUSY_TIMEOUT) and then idle again (WAIT_DONE).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus (slave)     producer channels and UART link, see uart_tx_arbiter_if
//   grant_id        index of the requester owning the link
//   busy            high in any state other than ARB
//   frame_done      one-cycle pulse on the cycle a frame completes
//   err_timeout     sticky: UART never went busy after tx_start
// Parameter constraints: ID_W == clog2(NUM_REQ), BUSY_TIMEOUT <= 2**TO_W.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int ID_W         = 2,
   parameter int BUSY_TIMEOUT = 64,
   parameter int TO_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   uart_tx_arbiter_if.slave bus,
   output logic [ID_W-1:0]  grant_id,
   output logic             busy,
   output logic             frame_done,
   output logic             err_timeout
);

   typedef enum logic [1:0] {
      ARB       = 2'd0,
      START     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   // One extra bit so rr_ptr + k cannot overflow before the modulo wrap.
   localparam int              IDX_W   = ID_W + 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

   state_t              r_state;
   state_t              w_next_state;
   logic [ID_W-1:0]     r_rr_ptr;
   logic [ID_W-1:0]     r_grant_id;
   logic [TO_W-1:0]     r_timer;
   logic                r_tx_start;
   logic [7:0]          r_tx_data;
   logic [1:0]          r_parity;
   logic                r_err_timeout;

   logic                w_found;
   logic [ID_W-1:0]     w_winner;
   logic [IDX_W-1:0]    w_idx;
   logic                w_transfer;
   logic                w_timeout;
   logic [NUM_REQ-1:0]  w_req_ready;

   // Round-robin search: first valid requester starting at rr_ptr.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      w_found  = 1'b0;
      w_winner = '0;
      w_idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = IDX_W'(r_rr_ptr) + IDX_W'(k);
         if (w_idx >= IDX_W'(NUM_REQ)) begin
            w_idx = w_idx - IDX_W'(NUM_REQ);
         end
         if (!w_found && bus.req_valid[w_idx[ID_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_idx[ID_W-1:0];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ARB;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // flop samples pre-edge values regardless of statement order.
         r_state <= w_next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ARB: begin
            if (w_transfer) w_next_state = START;
         end
         START: begin
            w_next_state = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (!bus.uart_tx_ready)  w_next_state = WAIT_DONE;
            else if (w_timeout)      w_next_state = ARB;
         end
         WAIT_DONE: begin
            if (bus.uart_tx_ready) w_next_state = ARB;
         end
         default: w_next_state = ARB;
      endcase
   end

   // Output decode.
   always_comb begin
      w_req_ready = '0;
      w_transfer  = 1'b0;
      w_timeout   = 1'b0;
      frame_done  = 1'b0;
      busy        = (r_state != ARB);
      case (r_state)
         ARB: begin
            // Gated by rst_n so no accept strobe escapes while reset is held
            // (state sits in ARB during reset and the search is combinational).
            if (w_found && rst_n) begin
               w_transfer            = 1'b1;
               w_req_ready[w_winner] = 1'b1;
            end
         end
         WAIT_BUSY: begin
            w_timeout = bus.uart_tx_ready && (r_timer == TO_LAST);
         end
         WAIT_DONE: begin
            frame_done = bus.uart_tx_ready;
         end
         default: ;
      endcase
   end

   // Datapath: captured frame, round-robin pointer, busy timer, error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_start    <= 1'b0;
         r_tx_data     <= '0;
         r_parity      <= '0;
         r_grant_id    <= '0;
         r_rr_ptr      <= '0;
         r_timer       <= '0;
         r_err_timeout <= 1'b0;
      end else begin
         // High exactly in the START cycle that follows the accept edge.
         r_tx_start <= w_transfer;

         // Data/parity/grant are only loaded on accept, so they stay frozen
         // until the frame ends; the UART samples parity during its start.
         if (w_transfer) begin
            r_tx_data  <= bus.req_data[8*w_winner +: 8];
            r_parity   <= bus.req_parity[2*w_winner +: 2];
            r_grant_id <= w_winner;
            r_rr_ptr   <= (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + ID_W'(1);
         end

         // Saturating: the timer never runs past the timeout value.
         if (r_state == START) begin
            r_timer <= '0;
         end else if ((r_state == WAIT_BUSY) && bus.uart_tx_ready && (r_timer != TO_LAST)) begin
            r_timer <= r_timer + TO_W'(1);
         end

         if (w_timeout) r_err_timeout <= 1'b1;
      end
   end

   assign bus.req_ready     = w_req_ready;
   assign bus.uart_tx_start = r_tx_start;
   assign bus.uart_tx_data  = r_tx_data;
   assign bus.uart_parity   = r_parity;
   assign grant_id          = r_grant_id;
   assign err_timeout       = r_err_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter. The bench plays both the producers
// and the UART (drives uart_tx_ready). A transaction-level reference model
// (round-robin pointer, last captured frame, sticky error, frame count) gives
// every expected value. Inputs change #1 after the rising edge; outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int NREQ = 4;

   logic       clk;
   logic       rst_n;
   logic [1:0] grant_id;
   logic       busy;
   logic       frame_done;
   logic       err_timeout;

   uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ      (NREQ),
      .ID_W         (2),
      .BUSY_TIMEOUT (64),
      .TO_W         (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .grant_id    (grant_id),
      .busy        (busy),
      .frame_done  (frame_done),
      .err_timeout (err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_err;
   int n_done_seen;
   int n_done_exp;

   // Reference model state.
   int         m_ptr;
   logic       m_err;
   logic [7:0] m_data;
   logic [1:0] m_par;
   logic [1:0] m_grant;

   always @(posedge clk) begin
      if (frame_done === 1'b1) n_done_seen++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Winner by the round-robin rule: first set bit scanning from ptr, modulo NREQ.
   function automatic int pick(input int ptr, input logic [3:0] mask);
      for (int k = 0; k < NREQ; k++) begin
         if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [7:0] rand_par();
      logic [7:0] p;
      for (int i = 0; i < NREQ; i++) p[2*i +: 2] = 2'($urandom_range(2, 0));
      return p;
   endfunction

   task automatic check_hold(input string tag);
      check({tag, "_data"},  bus.uart_tx_data, m_data);
      check({tag, "_par"},   bus.uart_parity,  m_par);
      check({tag, "_grant"}, grant_id,         m_grant);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"}, bus.req_ready,     0);
      check({tag, "_start"}, bus.uart_tx_start, 0);
      check({tag, "_data"},  bus.uart_tx_data,  0);
      check({tag, "_par"},   bus.uart_parity,   0);
      check({tag, "_grant"}, grant_id,          0);
      check({tag, "_busy"},  busy,              0);
      check({tag, "_done"},  frame_done,        0);
      check({tag, "_err"},   err_timeout,       0);
   endtask

   // Entered and left at posedge+1 with the DUT in ARB and no valid pending.
   task automatic idle(input int n);
      bus.req_valid = '0;
      repeat (n) begin
         @(negedge clk);
         check("idle_ready", bus.req_ready, 0);
         check("idle_busy",  busy, 0);
         check("idle_start", bus.uart_tx_start, 0);
         check_hold("idle");
         @(posedge clk); #1;
      end
   endtask

   // mode 0: normal frame, UART goes busy after lat cycles and stays busy low cycles
   // mode 1: UART never goes busy (timeout)
   // mode 2: reset asserted during WAIT_DONE (low must be >= 1)
   task automatic frame(input logic [3:0] mask, input logic [31:0] data, input logic [7:0] par,
                        input int lat, input int low, input int mode);
      int         win;
      logic [3:0] oh;
      win = pick(m_ptr, mask);
      oh  = 4'b0001 << win;
      bus.req_valid  = mask;
      bus.req_data   = data;
      bus.req_parity = par;

      // ARB cycle: accept strobe in the same cycle as valid.
      @(negedge clk);
      check("arb_busy",  busy, 0);
      check("req_ready", bus.req_ready, oh);
      check("arb_start", bus.uart_tx_start, 0);
      check("err_hold",  err_timeout, m_err);
      m_data  = data[8*win +: 8];
      m_par   = par[2*win +: 2];
      m_grant = 2'(win);
      m_ptr   = (win + 1) % NREQ;

      // START cycle; scramble producer inputs to show they no longer matter.
      @(posedge clk); #1;
      bus.req_valid  = 4'($urandom);
      bus.req_data   = $urandom;
      bus.req_parity = 8'($urandom);
      @(negedge clk);
      check("tx_start",    bus.uart_tx_start, 1);
      check("start_busy",  busy, 1);
      check("start_ready", bus.req_ready, 0);
      check_hold("start");
      @(posedge clk); #1;

      if (mode == 1) begin
         // Exactly BUSY_TIMEOUT cycles in WAIT_BUSY, then back to ARB.
         repeat (64) begin
            @(negedge clk);
            check("to_busy",  busy, 1);
            check("to_err",   err_timeout, m_err);
            check("to_done",  frame_done, 0);
            check("to_start", bus.uart_tx_start, 0);
            @(posedge clk); #1;
         end
         bus.req_valid = '0;
         m_err = 1'b1;
         check("to_err_set", err_timeout, 1);
         check("to_arb",     busy, 0);
         return;
      end

      repeat (lat) begin
         @(negedge clk);
         check("wb_start", bus.uart_tx_start, 0);
         check("wb_done",  frame_done, 0);
         check("wb_ready", bus.req_ready, 0);
         check_hold("wb");
         @(posedge clk); #1;
      end

      bus.uart_tx_ready = 1'b0;
      for (int c = 0; c < low; c++) begin
         @(negedge clk);
         check("wd_done", frame_done, 0);
         check("wd_busy", busy, 1);
         check_hold("wd");
         @(posedge clk); #1;
         bus.req_data   = $urandom;
         bus.req_parity = rand_par();
         if (mode == 2) begin
            #2;
            rst_n         = 1'b0;
            bus.req_valid = 4'hF;
            #1;
            check_reset_vals("rst_async");
            m_ptr   = 0;
            m_err   = 1'b0;
            m_data  = '0;
            m_par   = '0;
            m_grant = '0;
            bus.uart_tx_ready = 1'b1;
            @(negedge clk);
            check_reset_vals("rst_held");
            bus.req_valid = '0;
            rst_n = 1'b1;
            @(posedge clk); #1;
            return;
         end
      end

      bus.uart_tx_ready = 1'b1;
      @(negedge clk);
      check("frame_done", frame_done, 1);
      check_hold("done");
      n_done_exp++;
      @(posedge clk); #1;
      bus.req_valid = '0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      n_done_seen = 0;
      n_done_exp  = 0;
      m_ptr   = 0;
      m_err   = 1'b0;
      m_data  = '0;
      m_par   = '0;
      m_grant = '0;

      rst_n             = 1'b0;
      bus.req_valid     = '0;
      bus.req_data      = '0;
      bus.req_parity    = '0;
      bus.uart_tx_ready = 1'b1;
      #3;
      check_reset_vals("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      idle(3);

      // Single requester, long UART busy period.
      frame(4'b0001, {24'($urandom), 8'h55}, 8'b0000_0010, 3, 100, 0);
      idle(1);

      // All four held valid: grants 0,1,2,3,0 with bytes A0..A3,A0.
      for (int i = 0; i < 5; i++) begin
         frame(4'hF, 32'hA3A2_A1A0, rand_par(), $urandom_range(5, 0), $urandom_range(6, 1), 0);
      end

      // Pointer at 2 with only requester 1 valid wraps to 1; then all valid -> 2.
      frame(4'b0010, $urandom, rand_par(), 1, 2, 0);
      frame(4'b0010, $urandom, rand_par(), 1, 2, 0);
      frame(4'hF,    $urandom, rand_par(), 0, 1, 0);

      // UART never goes busy; next request still served with error sticky.
      frame(4'($urandom_range(15, 1)), $urandom, rand_par(), 0, 0, 1);
      idle(2);
      frame(4'($urandom_range(15, 1)), $urandom, rand_par(), 2, 3, 0);

      // Randomized traffic.
      for (int i = 0; i < 30; i++) begin
         frame(4'($urandom_range(15, 1)), $urandom, rand_par(),
               $urandom_range(20, 0), $urandom_range(12, 1), 0);
         idle($urandom_range(2, 0));
      end

      // Reset in WAIT_DONE, then all valid -> requester 0 first.
      frame(4'($urandom_range(15, 1)), $urandom, rand_par(), 1, 3, 2);
      frame(4'hF, $urandom, rand_par(), 1, 2, 0);
      idle(2);

      check("done_count", n_done_seen, n_done_exp);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
